// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, enabled interrupts and MRET,
// produces the CSR hardware write strobes/values and a fetch redirect.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        irq_soft,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        csr_rd_mstatus_mie,
    input  logic        csr_rd_mstatus_mpie,
    input  logic        csr_rd_mie_msie,
    input  logic        csr_rd_mie_mtie,
    input  logic        csr_rd_mie_meie,
    input  logic [29:0] csr_rd_mtvec_base,
    input  logic [1:0]  csr_rd_mtvec_mode,
    input  logic [31:0] csr_rd_mepc,
    output logic        csr_set_mip_msip,
    output logic        csr_set_mip_mtip,
    output logic        csr_set_mip_meip,
    output logic        trap,
    output logic        mret_commit,
    output logic        csr_wr_mstatus_mie,
    output logic        csr_wr_mstatus_mpie,
    output logic [31:0] csr_wr_mepc_mepc,
    output logic [31:0] csr_wr_mtval_mtval,
    output logic        csr_wr_mcause_interrupt,
    output logic [30:0] csr_wr_mcause_exception_code,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StTrap, StMret, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sync_soft_q, sync_timer_q, sync_ext_q;
    logic [30:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic        intr_q, intr_d;
    logic [31:0] target_q, target_d;

    logic        pend_s, pend_t, pend_e, pend_any;
    logic [3:0]  irq_code;
    logic [31:0] vec_base, trap_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_soft_q  <= '0;
            sync_timer_q <= '0;
            sync_ext_q   <= '0;
        end else begin
            sync_soft_q  <= {sync_soft_q[0], irq_soft};
            sync_timer_q <= {sync_timer_q[0], irq_timer};
            sync_ext_q   <= {sync_ext_q[0], irq_ext};
        end
    end

    assign csr_set_mip_msip = sync_soft_q[1];
    assign csr_set_mip_mtip = sync_timer_q[1];
    assign csr_set_mip_meip = sync_ext_q[1];

    assign pend_e   = sync_ext_q[1] & csr_rd_mie_meie & csr_rd_mstatus_mie;
    assign pend_s   = sync_soft_q[1] & csr_rd_mie_msie & csr_rd_mstatus_mie;
    assign pend_t   = sync_timer_q[1] & csr_rd_mie_mtie & csr_rd_mstatus_mie;
    assign pend_any = pend_e | pend_s | pend_t;

    always_comb begin
        irq_code = 4'd7;
        if (pend_e) begin
            irq_code = 4'd11;
        end else if (pend_s) begin
            irq_code = 4'd3;
        end
    end

    // Vectored offset applies to interrupts only; modes 2/3 fall back to direct.
    assign vec_base    = {csr_rd_mtvec_base, 2'b00};
    assign trap_target = (csr_rd_mtvec_mode == 2'd1 && intr_q) ?
                         vec_base + {cause_q[29:0], 2'b00} : vec_base;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        intr_d   = intr_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    cause_d = {27'd0, exc_code};
                    epc_d   = exc_pc;
                    tval_d  = exc_tval;
                    intr_d  = 1'b0;
                    state_d = StTrap;
                end else if (pend_any && commit_valid) begin
                    cause_d = {27'd0, irq_code};
                    epc_d   = commit_pc;
                    tval_d  = '0;
                    intr_d  = 1'b1;
                    state_d = StTrap;
                end else if (mret_valid) begin
                    state_d = StMret;
                end
            end
            StTrap: begin
                target_d = trap_target;
                state_d  = StRedirect;
            end
            StMret: begin
                target_d = csr_rd_mepc;
                state_d  = StRedirect;
            end
            StRedirect: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            intr_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            intr_q   <= intr_d;
            target_q <= target_d;
        end
    end

    // Outputs decode from state only, so reset clears them all at once.
    always_comb begin
        trap                         = 1'b0;
        mret_commit                  = 1'b0;
        flush                        = 1'b0;
        redirect_valid               = 1'b0;
        redirect_pc                  = '0;
        csr_wr_mstatus_mie           = 1'b0;
        csr_wr_mstatus_mpie          = 1'b0;
        csr_wr_mepc_mepc             = '0;
        csr_wr_mtval_mtval           = '0;
        csr_wr_mcause_interrupt      = 1'b0;
        csr_wr_mcause_exception_code = '0;
        unique case (state_q)
            StTrap: begin
                trap                         = 1'b1;
                flush                        = 1'b1;
                csr_wr_mstatus_mpie          = csr_rd_mstatus_mie;
                csr_wr_mepc_mepc             = epc_q;
                csr_wr_mtval_mtval           = tval_q;
                csr_wr_mcause_interrupt      = intr_q;
                csr_wr_mcause_exception_code = cause_q;
            end
            StMret: begin
                mret_commit         = 1'b1;
                flush               = 1'b1;
                csr_wr_mstatus_mie  = csr_rd_mstatus_mpie;
                csr_wr_mstatus_mpie = 1'b1;
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule
